// File: rtl/gate_response_checker_if.sv
// Stimulus/result bundle between a gate stimulus source and gate_response_checker.
// The stimulus source holds the master modport, the checker holds the slave modport.
interface gate_response_checker_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic [1:0]       op;
    logic [CNT_W-1:0] expect_n;
    logic             valid;
    logic             a;
    logic             b;
    logic             c;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] chk_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [2:0]       first_fail_vec;
    logic [CNT_W-1:0] first_fail_idx;
    logic [3:0]       cov;

    modport master (
        output start, op, expect_n, valid, a, b, c,
        input  busy, done, pass, chk_cnt, err_cnt, first_fail_vec, first_fail_idx, cov
    );

    modport slave (
        input  start, op, expect_n, valid, a, b, c,
        output busy, done, pass, chk_cnt, err_cnt, first_fail_vec, first_fail_idx, cov
    );
endinterface

// File: rtl/gate_response_checker.sv
// Checks a two-input gate's output against AND/OR/XOR/NAND over a run of vectors,
// counting checks and mismatches, capturing the first failure and input coverage.
//
// state | meaning
// IDLE  | waiting for start after reset
// RUN   | checking valid vectors until expect_n have been seen
// DONE  | results held, start begins a new run
module gate_response_checker #(
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    gate_response_checker_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    logic [1:0]       op_q;
    logic [CNT_W-1:0] n_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [CNT_W-1:0] chk_q;
    logic [CNT_W-1:0] err_q;
    logic [2:0]       ffv_q;
    logic [CNT_W-1:0] ffi_q;
    logic [3:0]       cov_q;

    logic             exp_c;
    logic             mis_c;
    logic [3:0]       cov_nxt;
    logic [CNT_W-1:0] err_nxt;
    logic             last_c;

    always_comb begin
        exp_c = 1'b0;
        case (op_q)
            2'b00:   exp_c = bus.a & bus.b;
            2'b01:   exp_c = bus.a | bus.b;
            2'b10:   exp_c = bus.a ^ bus.b;
            default: exp_c = ~(bus.a & bus.b);
        endcase
    end

    assign mis_c   = (bus.c != exp_c);
    assign cov_nxt = cov_q | (4'b0001 << {bus.a, bus.b});
    assign err_nxt = mis_c ? (err_q + CNT_ONE) : err_q;
    assign last_c  = ((chk_q + CNT_ONE) == n_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            op_q   <= 2'b00;
            n_q    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
            chk_q  <= '0;
            err_q  <= '0;
            ffv_q  <= 3'b000;
            ffi_q  <= '0;
            cov_q  <= 4'h0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        op_q   <= bus.op;
                        n_q    <= bus.expect_n;
                        chk_q  <= '0;
                        err_q  <= '0;
                        ffv_q  <= 3'b000;
                        ffi_q  <= '0;
                        cov_q  <= 4'h0;
                        pass_q <= 1'b0;
                        // An empty run finishes immediately with no coverage, so it never passes
                        if (bus.expect_n == '0) begin
                            state  <= DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            state  <= RUN;
                            busy_q <= 1'b1;
                            done_q <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (bus.valid) begin
                        cov_q <= cov_nxt;
                        chk_q <= chk_q + CNT_ONE;
                        err_q <= err_nxt;
                        if (mis_c && (err_q == '0)) begin
                            ffv_q <= {bus.a, bus.b, bus.c};
                            ffi_q <= chk_q;
                        end
                        if (last_c) begin
                            state  <= DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            pass_q <= (err_nxt == '0) && (cov_nxt == 4'hF);
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.pass           = pass_q;
    assign bus.chk_cnt        = chk_q;
    assign bus.err_cnt        = err_q;
    assign bus.first_fail_vec = ffv_q;
    assign bus.first_fail_idx = ffi_q;
    assign bus.cov            = cov_q;
endmodule

// File: tb/tb_gate_response_checker.sv
// Directed bench for gate_response_checker: one task per scenario, hand-computed expectations.
module tb_gate_response_checker;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    gate_response_checker_if #(.CNT_W(8)) bus ();

    gate_response_checker #(.CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [1:0] op, input logic [7:0] n);
        bus.start    = 1'b1;
        bus.op       = op;
        bus.expect_n = n;
        step();
        bus.start    = 1'b0;
    endtask

    task automatic send(input logic a, input logic b, input logic c);
        bus.valid = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.c     = c;
        step();
        bus.valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b1; bus.valid = 1'b1; bus.expect_n = 8'd3;
        step();
        step();
        bus.start = 1'b0; bus.valid = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b exp 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_done got %0b exp 0", bus.done); end
        checks++; if (bus.pass !== 1'b0) begin errors++; $display("FAIL rst_pass got %0b exp 0", bus.pass); end
        checks++; if (bus.chk_cnt !== 8'd0) begin errors++; $display("FAIL rst_chk got %0d exp 0", bus.chk_cnt); end
        checks++; if (bus.err_cnt !== 8'd0) begin errors++; $display("FAIL rst_err got %0d exp 0", bus.err_cnt); end
        checks++; if (bus.first_fail_vec !== 3'b000) begin errors++; $display("FAIL rst_ffv got %b exp 000", bus.first_fail_vec); end
        checks++; if (bus.first_fail_idx !== 8'd0) begin errors++; $display("FAIL rst_ffi got %0d exp 0", bus.first_fail_idx); end
        checks++; if (bus.cov !== 4'h0) begin errors++; $display("FAIL rst_cov got %h exp 0", bus.cov); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_and_pass();
        do_start(2'b00, 8'd4);
        checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL and_start busy/done got %0b/%0b exp 1/0", bus.busy, bus.done); end
        send(1'b0, 1'b0, 1'b0);
        bus.valid = 1'b1;
        bus.a = 1'b1; bus.b = 1'b0; bus.c = 1'b0; step();
        bus.a = 1'b0; bus.b = 1'b1; bus.c = 1'b0; step();
        checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL and_mid busy/done got %0b/%0b exp 1/0", bus.busy, bus.done); end
        checks++; if (bus.chk_cnt !== 8'd3) begin errors++; $display("FAIL and_mid_chk got %0d exp 3", bus.chk_cnt); end
        bus.a = 1'b1; bus.b = 1'b1; bus.c = 1'b1; step();
        bus.valid = 1'b0;
        checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL and_done busy/done got %0b/%0b exp 0/1", bus.busy, bus.done); end
        checks++; if (bus.pass !== 1'b1) begin errors++; $display("FAIL and_pass got %0b exp 1", bus.pass); end
        checks++; if (bus.chk_cnt !== 8'd4) begin errors++; $display("FAIL and_chk got %0d exp 4", bus.chk_cnt); end
        checks++; if (bus.err_cnt !== 8'd0) begin errors++; $display("FAIL and_err got %0d exp 0", bus.err_cnt); end
        checks++; if (bus.cov !== 4'hF) begin errors++; $display("FAIL and_cov got %h exp F", bus.cov); end
    endtask

    task automatic test_first_fail();
        do_start(2'b00, 8'd4);
        send(1'b0, 1'b0, 1'b0);
        send(1'b1, 1'b0, 1'b0);
        send(1'b0, 1'b1, 1'b1);
        checks++; if (bus.err_cnt !== 8'd1) begin errors++; $display("FAIL ff_err1 got %0d exp 1", bus.err_cnt); end
        checks++; if (bus.first_fail_vec !== 3'b011) begin errors++; $display("FAIL ff_vec1 got %b exp 011", bus.first_fail_vec); end
        checks++; if (bus.first_fail_idx !== 8'd2) begin errors++; $display("FAIL ff_idx1 got %0d exp 2", bus.first_fail_idx); end
        send(1'b1, 1'b1, 1'b0);
        checks++; if (bus.err_cnt !== 8'd2) begin errors++; $display("FAIL ff_err2 got %0d exp 2", bus.err_cnt); end
        checks++; if (bus.first_fail_vec !== 3'b011) begin errors++; $display("FAIL ff_vec2 got %b exp 011", bus.first_fail_vec); end
        checks++; if (bus.first_fail_idx !== 8'd2) begin errors++; $display("FAIL ff_idx2 got %0d exp 2", bus.first_fail_idx); end
        checks++; if (bus.done !== 1'b1 || bus.pass !== 1'b0) begin errors++; $display("FAIL ff_done/pass got %0b/%0b exp 1/0", bus.done, bus.pass); end
    endtask

    task automatic test_xor_cov();
        do_start(2'b10, 8'd3);
        checks++; if (bus.chk_cnt !== 8'd0 || bus.err_cnt !== 8'd0 || bus.cov !== 4'h0) begin errors++; $display("FAIL xor_clear chk/err/cov got %0d/%0d/%h exp 0/0/0", bus.chk_cnt, bus.err_cnt, bus.cov); end
        checks++; if (bus.first_fail_vec !== 3'b000 || bus.first_fail_idx !== 8'd0) begin errors++; $display("FAIL xor_clear_ff vec/idx got %b/%0d exp 000/0", bus.first_fail_vec, bus.first_fail_idx); end
        checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL xor_restart busy/done got %0b/%0b exp 1/0", bus.busy, bus.done); end
        bus.valid = 1'b1;
        bus.a = 1'b0; bus.b = 1'b0; bus.c = 1'b0; step();
        bus.a = 1'b0; bus.b = 1'b1; bus.c = 1'b1; step();
        bus.a = 1'b1; bus.b = 1'b0; bus.c = 1'b1; step();
        bus.valid = 1'b0;
        checks++; if (bus.cov !== 4'b0111) begin errors++; $display("FAIL xor_cov got %b exp 0111", bus.cov); end
        checks++; if (bus.err_cnt !== 8'd0) begin errors++; $display("FAIL xor_err got %0d exp 0", bus.err_cnt); end
        checks++; if (bus.done !== 1'b1 || bus.pass !== 1'b0) begin errors++; $display("FAIL xor_done/pass got %0b/%0b exp 1/0", bus.done, bus.pass); end
    endtask

    task automatic test_zero();
        do_start(2'b00, 8'd0);
        checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL zero busy/done got %0b/%0b exp 0/1", bus.busy, bus.done); end
        checks++; if (bus.pass !== 1'b0) begin errors++; $display("FAIL zero_pass got %0b exp 0", bus.pass); end
        checks++; if (bus.chk_cnt !== 8'd0) begin errors++; $display("FAIL zero_chk got %0d exp 0", bus.chk_cnt); end
    endtask

    task automatic test_gaps();
        do_start(2'b11, 8'd4);
        send(1'b0, 1'b0, 1'b1);
        step(); step();
        send(1'b0, 1'b1, 1'b1);
        bus.start = 1'b1; bus.op = 2'b00; bus.expect_n = 8'd1;
        step();
        bus.start = 1'b0;
        step();
        checks++; if (bus.busy !== 1'b1 || bus.chk_cnt !== 8'd2) begin errors++; $display("FAIL gap_ign busy/chk got %0b/%0d exp 1/2", bus.busy, bus.chk_cnt); end
        send(1'b1, 1'b0, 1'b1);
        step(); step();
        checks++; if (bus.done !== 1'b0 || bus.chk_cnt !== 8'd3) begin errors++; $display("FAIL gap_mid done/chk got %0b/%0d exp 0/3", bus.done, bus.chk_cnt); end
        send(1'b1, 1'b1, 1'b0);
        checks++; if (bus.done !== 1'b1 || bus.chk_cnt !== 8'd4) begin errors++; $display("FAIL gap_done done/chk got %0b/%0d exp 1/4", bus.done, bus.chk_cnt); end
        checks++; if (bus.err_cnt !== 8'd0 || bus.pass !== 1'b1) begin errors++; $display("FAIL gap_pass err/pass got %0d/%0b exp 0/1", bus.err_cnt, bus.pass); end
        send(1'b0, 1'b0, 1'b0);
        checks++; if (bus.chk_cnt !== 8'd4 || bus.err_cnt !== 8'd0 || bus.done !== 1'b1) begin errors++; $display("FAIL gap_post chk/err/done got %0d/%0d/%0b exp 4/0/1", bus.chk_cnt, bus.err_cnt, bus.done); end
    endtask

    task automatic test_reset_midrun();
        do_start(2'b01, 8'd4);
        send(1'b0, 1'b0, 1'b1);
        send(1'b1, 1'b0, 1'b1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.pass !== 1'b0) begin errors++; $display("FAIL mrst busy/done/pass got %0b/%0b/%0b exp 0/0/0", bus.busy, bus.done, bus.pass); end
        checks++; if (bus.chk_cnt !== 8'd0 || bus.err_cnt !== 8'd0 || bus.cov !== 4'h0) begin errors++; $display("FAIL mrst chk/err/cov got %0d/%0d/%h exp 0/0/0", bus.chk_cnt, bus.err_cnt, bus.cov); end
        checks++; if (bus.first_fail_vec !== 3'b000 || bus.first_fail_idx !== 8'd0) begin errors++; $display("FAIL mrst_ff vec/idx got %b/%0d exp 000/0", bus.first_fail_vec, bus.first_fail_idx); end
        send(1'b1, 1'b1, 1'b1);
        checks++; if (bus.chk_cnt !== 8'd0 || bus.busy !== 1'b0) begin errors++; $display("FAIL idle_valid chk/busy got %0d/%0b exp 0/0", bus.chk_cnt, bus.busy); end
        do_start(2'b01, 8'd4);
        send(1'b0, 1'b0, 1'b0);
        send(1'b0, 1'b1, 1'b1);
        send(1'b1, 1'b0, 1'b1);
        send(1'b1, 1'b1, 1'b1);
        checks++; if (bus.done !== 1'b1 || bus.pass !== 1'b1) begin errors++; $display("FAIL fresh done/pass got %0b/%0b exp 1/1", bus.done, bus.pass); end
        checks++; if (bus.chk_cnt !== 8'd4 || bus.err_cnt !== 8'd0 || bus.cov !== 4'hF) begin errors++; $display("FAIL fresh chk/err/cov got %0d/%0d/%h exp 4/0/F", bus.chk_cnt, bus.err_cnt, bus.cov); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.op = 2'b00; bus.expect_n = 8'd0;
        bus.valid = 1'b0; bus.a = 1'b0; bus.b = 1'b0; bus.c = 1'b0;
        test_reset();
        test_and_pass();
        test_first_fail();
        test_xor_cov();
        test_zero();
        test_gaps();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
